fpmulr8: RTL
============

Name: fpmulr8

Overview:
Iterative unsigned radix-8 multiplier, the inverse companion of the radix-8 divider in the fpUnit.
- Retires 3 multiplier bits per clock.
- Uses the same ld/done start-complete protocol, so the FP sequencer drives multiply and divide identically.
- Used for mantissa products in fmul, and for divide-result checking (q*b+r == a) in the test benches.

Parameters:
- WID, 33, operand width in bits.
- NITER, (WID+2)/3, iteration count (derived; do not override).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; low freezes all state except reset.
- ld  in  1  start pulse; samples a and b.
- a  in  WID  multiplicand.
- b  in  WID  multiplier.
- p  out  2*WID  product a*b, exact, unsigned.
- done  out  1  result valid.

Behaviour:
- Reset (rst=0, async): state=IDLE, p=0, done=0, cnt=0, internal shift registers 0.
- Registers:
  - acc: 2*WID bits, drives p directly.
  - ash: 2*WID bits, shifted multiplicand.
  - bsh: WID bits, remaining multiplier.
  - cnt: clog2(NITER+1) bits.
- States: IDLE, RUN, DONE.
- All transitions qualified by ce=1; with ce=0 nothing changes, including done.
- ld=1 in any state:
  - acc<=0, ash<=zero-extended a, bsh<=b, cnt<=0, done<=0, state<=RUN.
  - ld has priority over any RUN/DONE update in the same cycle, so ld mid-operation aborts and restarts.
- RUN, each ce cycle with ld=0:
  - d=bsh[2:0]; acc<=acc+ash*d, where ash*d is built from precomputed {0,1,2,3,4,5,6,7}×ash.
  - ash<=ash<<3; bsh<=bsh>>3; cnt<=cnt+1.
  - When cnt==NITER-1 the update is the last one: state<=DONE, done<=1.
- DONE: hold acc and done=1 until the next ld.
- IDLE: done=0, p holds its value (0 after reset).
- Latency: ld sampled at edge k → done=1 and p valid after edge k+NITER (11 edges for WID=33), assuming ce=1 throughout.
- Width rules:
  - The top digit is zero-padded when WID is not a multiple of 3.
  - acc never overflows 2*WID bits.
  - ash bits shifted beyond 2*WID are discarded.
- p changes during RUN (partial sums); consumers sample it only when done=1.
- Reset asserted mid-RUN: immediate return to reset values; the operation is lost.

Optional Feature:
- Macro FPMULR8_EARLY_EN.
  - Defined: in RUN, if bsh==0 at the start of an iteration (before the ld check fails), go to DONE on that edge with done<=1 and acc unchanged. Latency becomes min(NITER, ceil(msb(b)/3)+1); b=0 completes 1 edge after ld.
  - Undefined: fixed NITER latency regardless of operand values.

Decomposition:
- Package fpmulr8_pkg holds:
  - state encoding localparams IDLE/RUN/DONE;
  - the NITER derivation function;
  - the radix constant (3 bits/iteration).
- One sub-module, fpmulr8_ppsel: combinational digit-to-multiple selector (inputs ash, d; output ash*d, with 3x/5x/7x formed as adds).

Test Plan:
- a=33'h1000, b=33'h10, ld pulse, ce=1 → done rises 11 edges after ld, p=66'h10000; with FPMULR8_EARLY_EN, done after 3 edges, same p.
- a=b=33'h1_FFFF_FFFF → p=66'h3_FFFF_FFFC_0000_0001 after 11 edges.
- b=0, a=33'h1_2345_6789 → p=0; done after 11 edges (1 edge with FPMULR8_EARLY_EN).
- ld at edge k (a=3, b=5); second ld at edge k+4 (a=7, b=9) → no done before k+15; then p=63, done=1.
- ce held low for 5 cycles mid-RUN (a=1000, b=1000) → done delayed exactly 5 cycles; p=1000000 (66'hF4240).
- rst pulsed low mid-RUN → p=0, done=0 immediately (asynchronous); the next ld with a=2, b=3 gives p=6.

Source files
------------

// File: rtl/fpmulr8_pkg.sv
// Shared definitions for the radix-8 iterative multiplier: FSM states,
// digit width and the iteration-count derivation.
package fpmulr8_pkg;

  localparam int RADIX_BITS = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One iteration per multiplier digit; a partial top digit is zero-padded.
  function automatic int niter_f(input int wid);
    return (wid + RADIX_BITS - 1) / RADIX_BITS;
  endfunction

endpackage

// File: rtl/fpmulr8_if.sv
// Start/complete bus between the FP sequencer (master) and the multiplier (slave).
interface fpmulr8_if #(
  parameter int WID = 33
) ();

  logic             ce;
  logic             ld;
  logic [WID-1:0]   a;
  logic [WID-1:0]   b;
  logic [2*WID-1:0] p;
  logic             done;

  modport master (output ce, ld, a, b, input p, done);
  modport slave  (input ce, ld, a, b, output p, done);

endinterface

// File: rtl/fpmulr8_ppsel.sv
// Digit-to-multiple selector: returns ash*d for a 3-bit digit d, with the
// odd multiples built from shifted adds so no multiplier is inferred.
module fpmulr8_ppsel #(
  parameter int W = 66
) (
  input  logic [W-1:0] ash_i,
  input  logic [2:0]   d_i,
  output logic [W-1:0] pp_o
);

  logic [W-1:0] x2, x3, x4, x5, x6, x7;

  assign x2 = ash_i << 1;
  assign x4 = ash_i << 2;
  assign x3 = ash_i + x2;
  assign x5 = ash_i + x4;
  assign x6 = x3 << 1;
  assign x7 = x3 + x4;

  always_comb begin
    pp_o = '0;
    case (d_i)
      3'd0:    pp_o = '0;
      3'd1:    pp_o = ash_i;
      3'd2:    pp_o = x2;
      3'd3:    pp_o = x3;
      3'd4:    pp_o = x4;
      3'd5:    pp_o = x5;
      3'd6:    pp_o = x6;
      default: pp_o = x7;
    endcase
  end

endmodule

// File: rtl/fpmulr8.sv
// Iterative unsigned radix-8 multiplier, 3 multiplier bits retired per clock.
// Optional early completion when the remaining multiplier is zero: FPMULR8_EARLY_EN.
module fpmulr8
  import fpmulr8_pkg::*;
#(
  parameter int WID = 33
) (
  input  logic       clk,
  input  logic       rst,
  fpmulr8_if.slave   bus
);

  localparam int NITER = niter_f(WID);
  localparam int CW    = $clog2(NITER + 1);
  localparam int PW    = 2 * WID;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   ash_q, ash_d;
  logic [WID-1:0]  bsh_q, bsh_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [PW-1:0]   pp;

  fpmulr8_ppsel #(.W(PW)) u_ppsel (
    .ash_i (ash_q),
    .d_i   (bsh_q[2:0]),
    .pp_o  (pp)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ash_d   = ash_q;
    bsh_d   = bsh_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    // A new load always wins, so a load mid-operation aborts and restarts.
    if (bus.ld) begin
      acc_d   = '0;
      ash_d   = PW'(bus.a);
      bsh_d   = bus.b;
      cnt_d   = '0;
      done_d  = 1'b0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
`ifdef FPMULR8_EARLY_EN
          if (bsh_q == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
`else
          begin
`endif
            acc_d = acc_q + pp;
            ash_d = ash_q << RADIX_BITS;
            bsh_d = bsh_q >> RADIX_BITS;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(NITER - 1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        DONE: done_d = 1'b1;
        IDLE: done_d = 1'b0;
        default: begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ash_q   <= '0;
      bsh_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (bus.ce) begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ash_q   <= ash_d;
      bsh_q   <= bsh_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.p    = acc_q;
  assign bus.done = done_q;

endmodule
